dmem_ctrl: RTL and testbench

//  Two-requester controller in front of the single-port synchronous data RAM (1-cycle read latency).

---
 rtl/dmem_ctrl_pkg.sv | 34 +++
 rtl/dmem_lane_align.sv | 54 +++++
 rtl/dmem_ctrl.sv | 139 +++++++++++++
 tb/tb_dmem_ctrl.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/dmem_ctrl_pkg.sv
// Shared definitions for the data-memory controller: FSM states, funct3 codes
// and the access-legality decode.
package dmem_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_RD   = 3'd1,
        ST_WR   = 3'd2,
        ST_RESP = 3'd3,
        ST_ERR  = 3'd4
    } state_t;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    // Unknown width codes, unsigned stores and misaligned half/word accesses are rejected.
    function automatic logic is_illegal(input logic we, input logic [2:0] funct3,
                                        input logic [1:0] offset);
        logic bad;
        bad = 1'b0;
        case (funct3)
            3'b011, 3'b110, 3'b111: bad = 1'b1;
            default: ;
        endcase
        if (we && funct3[2])                          bad = 1'b1;
        if (funct3[1:0] == 2'b01 && offset[0])        bad = 1'b1;
        if (funct3[1:0] == 2'b10 && offset != 2'b00)  bad = 1'b1;
        return bad;
    endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Byte-lane steering between a 32-bit little-endian RAM word and the requester:
// load extract/extend and the store merge used by read-modify-write.
module dmem_lane_align
    import dmem_ctrl_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  offset,
    input  logic [31:0] word,
    input  logic [31:0] wdata,
    output logic [31:0] load_data,
    output logic [31:0] store_word
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    assign byte_sel = word[{offset, 3'b000} +: 8];
    assign half_sel = word[{offset[1], 4'b0000} +: 16];

    always_comb begin
        load_data = word;
        case (funct3)
            F3_B:    load_data = {{24{byte_sel[7]}}, byte_sel};
            F3_H:    load_data = {{16{half_sel[15]}}, half_sel};
            F3_BU:   load_data = {24'd0, byte_sel};
            F3_HU:   load_data = {16'd0, half_sel};
            default: load_data = word;
        endcase
    end

    // Each lane either keeps the old RAM byte or takes the matching store byte.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            localparam logic [1:0] LANE = 2'(gi);
            localparam int         HB   = 8 * (gi % 2);
            logic       hit;
            logic [7:0] src;

            always_comb begin
                hit = 1'b0;
                src = wdata[7:0];
                case (funct3[1:0])
                    2'b10: begin hit = 1'b1;                 src = wdata[8*gi +: 8]; end
                    2'b01: begin hit = (offset[1] == LANE[1]); src = wdata[HB +: 8];  end
                    default: begin hit = (offset == LANE);   src = wdata[7:0];       end
                endcase
            end

            assign store_word[8*gi +: 8] = hit ? src : word[8*gi +: 8];
        end
    endgenerate

endmodule

// File: rtl/dmem_ctrl.sv
// Two-requester front end for a single-port synchronous data RAM: arbitration,
// legality check, load extension and read-modify-write sub-word stores.
module dmem_ctrl
    import dmem_ctrl_pkg::*;
#(
    parameter int MEM_AW     = 12,
    parameter bit PRIO_FIXED = 1'b0
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic [1:0]        m_req,
    input  logic [1:0]        m_we,
    input  logic [5:0]        m_funct3,
    input  logic [63:0]       m_addr,
    input  logic [63:0]       m_wdata,
    output logic [1:0]        m_ack,
    output logic              m_err,
    output logic [31:0]       m_rdata,
    output logic [MEM_AW-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              mem_wren,
    input  logic [31:0]       mem_q
);

    state_t              state_reg, state_next;
    logic                id_reg, we_reg, last_reg;
    logic [2:0]          f3_reg;
    logic [MEM_AW+1:0]   addr_reg;
    logic [31:0]         wdata_reg;
    logic [1:0]          ack_reg;
    logic                err_reg;
    logic [31:0]         rdata_reg;

    logic                win, win_we, win_bad, accept, resp_next, ack_id;
    logic [2:0]          win_f3;
    logic [MEM_AW+1:0]   win_addr;
    logic [31:0]         win_wdata;
    logic [31:0]         load_data, store_word;
    logic                unused_addr_bits;

    assign unused_addr_bits = ^{m_addr[63:32+MEM_AW+2], m_addr[31:MEM_AW+2]};

    // Round robin hands a tie to whoever was not granted last.
    always_comb begin
        if (PRIO_FIXED)         win = ~m_req[0];
        else if (&m_req)        win = ~last_reg;
        else                    win = m_req[1];
    end

    assign accept    = (state_reg == ST_IDLE) && (|m_req);
    assign win_we    = m_we[win];
    assign win_f3    = win ? m_funct3[5:3] : m_funct3[2:0];
    assign win_addr  = win ? m_addr[32 +: MEM_AW+2] : m_addr[0 +: MEM_AW+2];
    assign win_wdata = win ? m_wdata[63:32] : m_wdata[31:0];
    assign win_bad   = is_illegal(win_we, win_f3, win_addr[1:0]);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) state_reg <= ST_IDLE;
        else          state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: begin
                if (accept) begin
                    if (win_bad)                              state_next = ST_ERR;
                    else if (win_we && win_f3[1:0] == 2'b10)  state_next = ST_WR;
                    else                                      state_next = ST_RD;
                end
            end
            ST_RD:   state_next = we_reg ? ST_WR : ST_RESP;
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            id_reg    <= 1'b0;
            we_reg    <= 1'b0;
            f3_reg    <= 3'd0;
            addr_reg  <= '0;
            wdata_reg <= '0;
            last_reg  <= 1'b1;
        end else if (accept) begin
            id_reg    <= win;
            we_reg    <= win_we;
            f3_reg    <= win_f3;
            addr_reg  <= win_addr;
            wdata_reg <= win_wdata;
            last_reg  <= win;
        end
    end

    // Ack/err are registered on entry to the completing state so they pulse in it.
    assign resp_next = (state_next == ST_WR) || (state_next == ST_RESP) || (state_next == ST_ERR);
    assign ack_id    = (state_reg == ST_IDLE) ? win : id_reg;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            ack_reg   <= 2'b00;
            err_reg   <= 1'b0;
            rdata_reg <= '0;
        end else begin
            ack_reg[0] <= resp_next & ~ack_id;
            ack_reg[1] <= resp_next & ack_id;
            err_reg    <= (state_next == ST_ERR);
            if (state_reg == ST_RESP) rdata_reg <= load_data;
        end
    end

    always_comb begin
        mem_wren  = 1'b0;
        mem_wdata = '0;
        m_rdata   = rdata_reg;
        case (state_reg)
            ST_WR: begin
                mem_wren  = 1'b1;
                mem_wdata = store_word;
            end
            ST_RESP: m_rdata = load_data;
            default: ;
        endcase
    end

    assign mem_addr = addr_reg[MEM_AW+1:2];
    assign m_ack    = ack_reg;
    assign m_err    = err_reg;

    dmem_lane_align u_align (
        .funct3     (f3_reg),
        .offset     (addr_reg[1:0]),
        .word       (mem_q),
        .wdata      (wdata_reg),
        .load_data  (load_data),
        .store_word (store_word)
    );

endmodule

// File: tb/tb_dmem_ctrl.sv
// Directed bench for dmem_ctrl: a round-robin and a fixed-priority instance share
// stimulus, each with its own behavioural synchronous RAM.
module tb_dmem_ctrl;

    localparam int AW = 12;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          reset_n;
    logic [1:0]    req, we;
    logic [5:0]    f3;
    logic [63:0]   addr, wdata;

    logic [1:0]    ack0, ack1;
    logic          err0, err1, wren0, wren1;
    logic [31:0]   rdata0, rdata1, mwdata0, mwdata1, q0, q1;
    logic [AW-1:0] maddr0, maddr1;

    logic [31:0]   ram0 [0:(1<<AW)-1];
    logic [31:0]   ram1 [0:(1<<AW)-1];

    dmem_ctrl #(.MEM_AW(AW), .PRIO_FIXED(1'b0)) dut0 (
        .clock(clk), .reset_n(reset_n), .m_req(req), .m_we(we), .m_funct3(f3),
        .m_addr(addr), .m_wdata(wdata), .m_ack(ack0), .m_err(err0), .m_rdata(rdata0),
        .mem_addr(maddr0), .mem_wdata(mwdata0), .mem_wren(wren0), .mem_q(q0));

    dmem_ctrl #(.MEM_AW(AW), .PRIO_FIXED(1'b1)) dut1 (
        .clock(clk), .reset_n(reset_n), .m_req(req), .m_we(we), .m_funct3(f3),
        .m_addr(addr), .m_wdata(wdata), .m_ack(ack1), .m_err(err1), .m_rdata(rdata1),
        .mem_addr(maddr1), .mem_wdata(mwdata1), .mem_wren(wren1), .mem_q(q1));

    always @(posedge clk) begin
        if (wren0) ram0[maddr0] <= mwdata0;
        q0 <= ram0[maddr0];
        if (wren1) ram1[maddr1] <= mwdata1;
        q1 <= ram1[maddr1];
    end

    int checks = 0;
    int errors = 0;

    logic [1:0]    c_ack;
    logic          c_err;
    logic [31:0]   c_rd, c_wd;
    logic [AW-1:0] c_ma;
    int            c_lat, c_wcnt;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drive(input int id, input logic w, input logic [2:0] f,
                         input logic [31:0] a, input logic [31:0] d);
        if (id == 0) begin
            we[0] = w; f3[2:0] = f; addr[31:0] = a; wdata[31:0] = d; req[0] = 1'b1;
        end else begin
            we[1] = w; f3[5:3] = f; addr[63:32] = a; wdata[63:32] = d; req[1] = 1'b1;
        end
    endtask

    task automatic wait_ack0();
        c_lat = 0; c_wcnt = 0; c_ack = 2'b00; c_err = 1'b0;
        c_rd = '0; c_wd = '0; c_ma = '0;
        while (c_ack == 2'b00 && c_lat < 8) begin
            @(posedge clk); #1;
            c_lat++;
            if (wren0) c_wcnt++;
            c_ack = ack0; c_err = err0; c_rd = rdata0; c_wd = mwdata0; c_ma = maddr0;
        end
    endtask

    // One complete transaction on dut0; exp_v is load data or the expected RAM write word.
    task automatic txn(input string tag, input int id, input logic w, input logic [2:0] f,
                       input logic [31:0] a, input logic [31:0] d, input int exp_lat,
                       input logic exp_err, input logic [31:0] exp_v);
        drive(id, w, f, a, d);
        wait_ack0();
        req[id] = 1'b0;
        chk({tag, ".lat"}, 32'(c_lat), 32'(exp_lat));
        chk({tag, ".ack"}, {30'd0, c_ack}, (id == 0) ? 32'd1 : 32'd2);
        chk({tag, ".err"}, {31'd0, c_err}, {31'd0, exp_err});
        if (exp_err) begin
            chk({tag, ".wren_cnt"}, 32'(c_wcnt), 32'd0);
        end else if (w) begin
            chk({tag, ".wdata"}, c_wd, exp_v);
            chk({tag, ".maddr"}, 32'(c_ma), 32'(a[AW+1:2]));
            chk({tag, ".wren_cnt"}, 32'(c_wcnt), 32'd1);
        end else begin
            chk({tag, ".rdata"}, c_rd, exp_v);
            chk({tag, ".wren_cnt"}, 32'(c_wcnt), 32'd0);
        end
        @(posedge clk); #1;
        chk({tag, ".after"}, {29'd0, ack0, err0}, 32'd0);
        $display("txn %s id=%0d we=%0b f3=%03b addr=%h lat=%0d ack=%b err=%b rdata=%h wdata=%h",
                 tag, id, w, f, a, c_lat, c_ack, c_err, c_rd, c_wd);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0]  seq_ack [4];
        logic [31:0] seq_rd  [4];
        int n_ack, cyc, d1_m0, d1_m1, bad;
        logic [1:0]  a1;
        logic [31:0] r1;
        logic        e1;

        reset_n = 1'b0;
        req = 2'b00; we = 2'b00; f3 = '0; addr = '0; wdata = '0;
        for (int i = 0; i < (1 << AW); i++) begin
            ram0[i] = 32'hA500_0000 | i;
            ram1[i] = 32'hA500_0000 | i;
        end

        repeat (3) @(posedge clk);
        #1;
        chk("rst.ack",   {30'd0, ack0}, 32'd0);
        chk("rst.err",   {31'd0, err0}, 32'd0);
        chk("rst.rdata", rdata0, 32'd0);
        chk("rst.wren",  {31'd0, wren0}, 32'd0);
        chk("rst.maddr", 32'(maddr0), 32'd0);
        chk("rst.wdata", mwdata0, 32'd0);
        @(negedge clk); reset_n = 1'b1;
        @(posedge clk); #1;

        // Word store, sub-word loads and read-modify-write stores
        txn("sw10",   0, 1'b1, 3'b010, 32'h10, 32'h1122_3344, 1, 1'b0, 32'h1122_3344);
        txn("lb13",   0, 1'b0, 3'b000, 32'h13, 32'h0,         2, 1'b0, 32'h0000_0011);
        txn("sb12",   0, 1'b1, 3'b000, 32'h12, 32'h0000_00AB, 2, 1'b0, 32'h11AB_3344);
        txn("lw10",   0, 1'b0, 3'b010, 32'h10, 32'h0,         2, 1'b0, 32'h11AB_3344);
        txn("lb12",   0, 1'b0, 3'b000, 32'h12, 32'h0,         2, 1'b0, 32'hFFFF_FFAB);
        txn("lbu12",  0, 1'b0, 3'b100, 32'h12, 32'h0,         2, 1'b0, 32'h0000_00AB);
        txn("sh10",   0, 1'b1, 3'b001, 32'h10, 32'h0000_8001, 2, 1'b0, 32'h11AB_8001);
        txn("lh10",   0, 1'b0, 3'b001, 32'h10, 32'h0,         2, 1'b0, 32'hFFFF_8001);
        txn("lhu10",  0, 1'b0, 3'b101, 32'h10, 32'h0,         2, 1'b0, 32'h0000_8001);
        txn("lh12",   0, 1'b0, 3'b001, 32'h12, 32'h0,         2, 1'b0, 32'h0000_11AB);

        // Illegal accesses: misaligned, bad funct3, unsigned store
        txn("sh11",   0, 1'b1, 3'b001, 32'h11, 32'h1234,      1, 1'b1, 32'h0);
        txn("f3_011", 0, 1'b0, 3'b011, 32'h10, 32'h0,         1, 1'b1, 32'h0);
        txn("st_100", 0, 1'b1, 3'b100, 32'h10, 32'hAA,        1, 1'b1, 32'h0);
        txn("lw12",   0, 1'b0, 3'b010, 32'h12, 32'h0,         1, 1'b1, 32'h0);
        txn("m1_111", 1, 1'b0, 3'b111, 32'h10, 32'h0,         1, 1'b1, 32'h0);
        txn("m1_lw10",1, 1'b0, 3'b010, 32'h10, 32'h0,         2, 1'b0, 32'h11AB_8001);

        // Both requesters hold loads: RR alternates, fixed priority starves m1
        for (int i = 0; i < 4; i++) begin seq_ack[i] = 2'b00; seq_rd[i] = '0; end
        drive(0, 1'b0, 3'b010, 32'h20, 32'h0);
        drive(1, 1'b0, 3'b010, 32'h24, 32'h0);
        n_ack = 0; cyc = 0; d1_m0 = 0; d1_m1 = 0;
        while (n_ack < 4 && cyc < 40) begin
            @(posedge clk); #1;
            cyc++;
            if (ack0 != 2'b00) begin
                seq_ack[n_ack] = ack0; seq_rd[n_ack] = rdata0; n_ack++;
            end
            if (ack1 == 2'b01) d1_m0++;
            if (ack1 == 2'b10) d1_m1++;
        end
        req[0] = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("rr.ack%0d", i), {30'd0, seq_ack[i]}, (i % 2 == 0) ? 32'd1 : 32'd2);
            chk($sformatf("rr.rdata%0d", i), seq_rd[i], (i % 2 == 0) ? 32'hA500_0008 : 32'hA500_0009);
            $display("rr grant %0d ack=%b rdata=%h", i, seq_ack[i], seq_rd[i]);
        end
        chk("fix.m0_acks", 32'(d1_m0), 32'd4);
        chk("fix.m1_acks", 32'(d1_m1), 32'd0);
        cyc = 0; a1 = 2'b00; r1 = '0; e1 = 1'b0;
        while (a1 == 2'b00 && cyc < 10) begin
            @(posedge clk); #1;
            cyc++;
            a1 = ack1; r1 = rdata1; e1 = err1;
        end
        req[1] = 1'b0;
        chk("fix.m1_ack",   {30'd0, a1}, 32'd2);
        chk("fix.m1_err",   {31'd0, e1}, 32'd0);
        chk("fix.m1_rdata", r1, 32'hA500_0009);
        $display("fixed prio m1 served after m0 dropped ack=%b rdata=%h", a1, r1);
        repeat (4) @(posedge clk);
        #1;

        // Reset during the read phase of a half-word store
        drive(0, 1'b1, 3'b001, 32'h14, 32'h5555);
        @(posedge clk); #1;
        chk("rst5.rd_maddr", 32'(maddr0), 32'd5);
        #2 reset_n = 1'b0;
        #1;
        chk("rst5.ack",   {30'd0, ack0}, 32'd0);
        chk("rst5.err",   {31'd0, err0}, 32'd0);
        chk("rst5.rdata", rdata0, 32'd0);
        chk("rst5.wren",  {31'd0, wren0}, 32'd0);
        chk("rst5.maddr", 32'(maddr0), 32'd0);
        chk("rst5.wdata", mwdata0, 32'd0);
        req[0] = 1'b0;
        bad = 0;
        repeat (3) begin
            @(posedge clk); #1;
            if (wren0 || ack0 != 2'b00) bad++;
        end
        chk("rst5.quiet", 32'(bad), 32'd0);
        @(negedge clk); reset_n = 1'b1;
        @(posedge clk); #1;
        txn("m1_lw14", 1, 1'b0, 3'b010, 32'h14, 32'h0, 2, 1'b0, 32'hA500_0005);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
